// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw pin inputs and conditioned PIO-side outputs.
// master drives raw keys/switches; slave (the conditioner) drives the rest.
interface input_conditioner_if #(
  parameter int N_BUTTONS  = 2,
  parameter int N_SWITCHES = 10
);
  logic [N_BUTTONS-1:0]  buttons_n_raw;
  logic [N_SWITCHES-1:0] switches_raw;
  logic [N_BUTTONS-1:0]  buttons_level;
  logic [N_BUTTONS-1:0]  buttons_press;
  logic [N_BUTTONS-1:0]  buttons_long;
  logic [N_BUTTONS-1:0]  buttons_repeat;
  logic [N_SWITCHES-1:0] switches_level;
  logic                  switches_changed;

  modport master (
    output buttons_n_raw,
    output switches_raw,
    input  buttons_level,
    input  buttons_press,
    input  buttons_long,
    input  buttons_repeat,
    input  switches_level,
    input  switches_changed
  );

  modport slave (
    input  buttons_n_raw,
    input  switches_raw,
    output buttons_level,
    output buttons_press,
    output buttons_long,
    output buttons_repeat,
    output switches_level,
    output switches_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: 2-FF sync + debounce of keys/switches, per-button
// press/long/repeat pulses and a switch-change strobe.
// Ports: clk_clk, reset_reset (sync, active-high), io (slave modport):
//   buttons_n_raw/switches_raw in; buttons_level/press/long/repeat,
//   switches_level, switches_changed out (all registered).
module input_conditioner #(
  parameter int N_BUTTONS         = 2,
  parameter int N_SWITCHES        = 10,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000
) (
  input logic                clk_clk,
  input logic                reset_reset,
  input_conditioner_if.slave io
);
  localparam int NB = N_BUTTONS;
  localparam int W  = N_BUTTONS + N_SWITCHES;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  // long fires on the edge the hold count would reach
  // LONG_PRESS_CYCLES-1, i.e. that many edges after the press pulse
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_PRESS_CYCLES - 2);
  localparam logic [RW-1:0] REP_LAST =
    RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } btn_st_e;

  logic [NB-1:0]         bsync1_q;
  logic [NB-1:0]         bsync2_q;
  logic [N_SWITCHES-1:0] ssync1_q;
  logic [N_SWITCHES-1:0] ssync2_q;

  // buttons in pressed-high polarity, switches above them
  logic [W-1:0]  synced;
  logic [W-1:0]  stable_q;
  logic [W-1:0]  stable_d;
  logic [DW-1:0] db_cnt_q [W];
  logic [DW-1:0] db_cnt_d [W];

  btn_st_e       st_q   [NB];
  btn_st_e       st_d   [NB];
  logic [HW-1:0] hold_q [NB];
  logic [HW-1:0] hold_d [NB];
  logic [RW-1:0] rep_q  [NB];
  logic [RW-1:0] rep_d  [NB];

  logic [NB-1:0] press_q;
  logic [NB-1:0] press_d;
  logic [NB-1:0] long_q;
  logic [NB-1:0] long_d;
  logic [NB-1:0] repeat_q;
  logic [NB-1:0] repeat_d;
  logic          chg_q;
  logic          chg_d;

  logic [NB-1:0] rise;
  logic [NB-1:0] fall;

  assign synced = {ssync2_q, ~bsync2_q};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < W; i++) begin
      db_cnt_d[i] = '0;
      if (synced[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = synced[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign rise  = stable_d[NB-1:0] & ~stable_q[NB-1:0];
  assign fall  = ~stable_d[NB-1:0] & stable_q[NB-1:0];
  assign chg_d = |(stable_d[W-1:NB] ^ stable_q[W-1:NB]);

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      st_d[b]     = st_q[b];
      hold_d[b]   = hold_q[b];
      rep_d[b]    = rep_q[b];
      press_d[b]  = 1'b0;
      long_d[b]   = 1'b0;
      repeat_d[b] = 1'b0;
      if (fall[b]) begin
        st_d[b]   = IDLE;
        hold_d[b] = '0;
        rep_d[b]  = '0;
      end else begin
        unique case (st_q[b])
          IDLE: begin
            if (rise[b]) begin
              st_d[b]    = PRESSED;
              press_d[b] = 1'b1;
              hold_d[b]  = '0;
            end
          end
          PRESSED: begin
            if (hold_q[b] == HOLD_LAST) begin
              st_d[b]   = HELD;
              long_d[b] = 1'b1;
              hold_d[b] = '0;
              rep_d[b]  = '0;
            end else begin
              hold_d[b] = hold_q[b] + HW'(1);
            end
          end
          HELD: begin
            if (rep_q[b] == REP_LAST) begin
              repeat_d[b] = 1'b1;
              rep_d[b]    = '0;
            end else begin
              rep_d[b] = rep_q[b] + RW'(1);
            end
          end
          default: begin
            st_d[b] = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bsync1_q <= '1;
      bsync2_q <= '1;
      ssync1_q <= '0;
      ssync2_q <= '0;
      stable_q <= '0;
      for (int i = 0; i < W; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int b = 0; b < NB; b++) begin
        st_q[b]   <= IDLE;
        hold_q[b] <= '0;
        rep_q[b]  <= '0;
      end
      press_q  <= '0;
      long_q   <= '0;
      repeat_q <= '0;
      chg_q    <= 1'b0;
    end else begin
      bsync1_q <= io.buttons_n_raw;
      bsync2_q <= bsync1_q;
      ssync1_q <= io.switches_raw;
      ssync2_q <= ssync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < W; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int b = 0; b < NB; b++) begin
        st_q[b]   <= st_d[b];
        hold_q[b] <= hold_d[b];
        rep_q[b]  <= rep_d[b];
      end
      press_q  <= press_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      chg_q    <= chg_d;
    end
  end

  assign io.buttons_level    = stable_q[NB-1:0];
  assign io.switches_level   = stable_q[W-1:NB];
  assign io.buttons_press    = press_q;
  assign io.buttons_long     = long_q;
  assign io.buttons_repeat   = repeat_q;
  assign io.switches_changed = chg_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed + random scenarios against a
// window/age based reference model of the input conditioner.
module tb_input_conditioner;
  localparam int NB = 2;
  localparam int NS = 10;
  localparam int D  = 4;
  localparam int L  = 20;
  localparam int R  = 8;
  localparam int W  = NB + NS;
  localparam int VW = 4 * NB + NS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  input_conditioner_if #(.N_BUTTONS(NB), .N_SWITCHES(NS)) bus ();

  input_conditioner #(
    .N_BUTTONS(NB),
    .N_SWITCHES(NS),
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .io(bus.slave)
  );

  // model: raw samples (pressed-high), newest first
  logic [W-1:0]  rq [D+2];
  logic [W-1:0]  m_stable;
  logic [NB-1:0] m_press;
  logic [NB-1:0] m_long;
  logic [NB-1:0] m_rep;
  logic          m_chg;
  int            age [NB];

  // a level is accepted once the value seen through the 2-FF delay
  // has disagreed with the accepted level for D consecutive edges;
  // gestures are derived from the age of the press in edges
  task automatic model_edge();
    logic [W-1:0] prev;
    logic [W-1:0] nxt;
    bit hit;
    m_press = '0;
    m_long  = '0;
    m_rep   = '0;
    m_chg   = 1'b0;
    if (rst) begin
      for (int i = 0; i < D + 2; i++) rq[i] = '0;
      m_stable = '0;
      for (int b = 0; b < NB; b++) age[b] = 0;
      return;
    end
    for (int i = D + 1; i > 0; i--) rq[i] = rq[i-1];
    rq[0] = {bus.switches_raw, ~bus.buttons_n_raw};
    prev = m_stable;
    nxt  = m_stable;
    for (int b = 0; b < W; b++) begin
      hit = 1'b1;
      for (int k = 2; k < D + 2; k++)
        if (rq[k][b] == prev[b]) hit = 1'b0;
      if (hit) nxt[b] = ~prev[b];
    end
    m_stable = nxt;
    m_chg = (nxt[W-1:NB] != prev[W-1:NB]);
    for (int b = 0; b < NB; b++) begin
      if (nxt[b] && !prev[b]) begin
        m_press[b] = 1'b1;
        age[b] = 0;
      end else if (nxt[b]) begin
        age[b]++;
        if (age[b] == L - 1) m_long[b] = 1'b1;
        else if (age[b] > L - 1 && (age[b] - (L - 1)) % R == 0)
          m_rep[b] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.buttons_level, bus.buttons_press, bus.buttons_long,
            bus.buttons_repeat, bus.switches_level,
            bus.switches_changed};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_stable[NB-1:0], m_press, m_long, m_rep,
            m_stable[W-1:NB], m_chg};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.buttons_n_raw = '1;
    bus.switches_raw  = '0;
    repeat (3) tick();
    n_chk++;
    if (dut_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int pe = -1;
    int np = 0;
    logic [NB-1:0] lv6 = '0;
    bus.buttons_n_raw = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL clean_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_press != '0) begin
        np++;
        if (pe < 0) pe = k;
      end
      if (k == 6) lv6 = bus.buttons_level;
    end
    n_chk++;
    if (pe != 6 || np != 1) begin
      n_err++;
      $display("FAIL clean_press_edge got=%0d/%0d exp=6/1", pe, np);
    end
    n_chk++;
    if (lv6 !== 2'b01) begin
      n_err++;
      $display("FAIL clean_level6 got=%b exp=01", lv6);
    end
    bus.buttons_n_raw = 2'b11;
    idle(10);
  endtask

  task automatic test_bounce();
    int np = 0;
    int pe = -1;
    int lvb = 0;
    for (int k = 0; k < 12; k++) begin
      bus.buttons_n_raw[0] = ((k / 2) % 2 == 1);
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL bounce_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_level[0]) lvb++;
      if (bus.buttons_press[0]) np++;
    end
    bus.buttons_n_raw[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL bounce_model2 k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_press[0]) begin
        np++;
        if (pe < 0) pe = k;
      end
    end
    n_chk++;
    if (np != 1 || pe != 6 || lvb != 0) begin
      n_err++;
      $display("FAIL bounce_press got=%0d/%0d/%0d exp=1/6/0",
               np, pe, lvb);
    end
    bus.buttons_n_raw = 2'b11;
    idle(10);
  endtask

  task automatic test_long_repeat();
    int p = -1;
    int lg = -1;
    int rel = -1;
    int fl = -1;
    int extra = 0;
    int reps[$];
    int exp_rep[5] = '{27, 35, 43, 51, 59};
    bus.buttons_n_raw = 2'b10;
    for (int k = 1; k <= 150 && fl < 0; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL long_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_press[0] && p < 0) p = k;
      if (bus.buttons_long[0]) lg = k;
      if (bus.buttons_repeat[0]) reps.push_back(k - p);
      if (rel >= 0 && !bus.buttons_level[0]) fl = k;
      if (p >= 0 && k == p + 60) begin
        bus.buttons_n_raw = 2'b11;
        rel = k;
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.buttons_long != '0 || bus.buttons_repeat != '0) extra++;
    end
    n_chk++;
    if (p < 0 || lg - p != 19) begin
      n_err++;
      $display("FAIL long_offset got=%0d exp=19", lg - p);
    end
    n_chk++;
    if (reps.size() != 5) begin
      n_err++;
      $display("FAIL repeat_count got=%0d exp=5", reps.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= reps.size() || reps[i] != exp_rep[i]) begin
        n_err++;
        $display("FAIL repeat_offset i=%0d got=%0d exp=%0d", i,
                 (i < reps.size()) ? reps[i] : -1, exp_rep[i]);
      end
    end
    n_chk++;
    if (fl < 0 || fl - rel != 6 || extra != 0) begin
      n_err++;
      $display("FAIL release_fall got=%0d/%0d exp=6/0",
               fl - rel, extra);
    end
  endtask

  task automatic test_short_press();
    int np = 0;
    int nl = 0;
    int nh = 0;
    for (int k = 0; k < 30; k++) begin
      bus.buttons_n_raw[0] = (k >= 10);
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL short_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_press[0]) np++;
      if (bus.buttons_long[0] || bus.buttons_repeat[0]) nl++;
      if (bus.buttons_level[0]) nh++;
    end
    n_chk++;
    if (np != 1 || nl != 0 || nh != 10) begin
      n_err++;
      $display("FAIL short_press got=%0d/%0d/%0d exp=1/0/10",
               np, nl, nh);
    end
  endtask

  task automatic test_switches();
    int le = -1;
    int nc = 0;
    int bad = 0;
    bus.switches_raw = 10'h2A5;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL sw_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.switches_level == 10'h2A5 && le < 0) le = k;
      if (bus.switches_changed) nc++;
    end
    n_chk++;
    if (le != 6 || nc != 1) begin
      n_err++;
      $display("FAIL sw_settle got=%0d/%0d exp=6/1", le, nc);
    end
    nc = 0;
    for (int k = 0; k < 14; k++) begin
      bus.switches_raw[9] = !(k < 3);
      tick();
      if (bus.switches_changed) nc++;
      if (bus.switches_level !== 10'h2A5) bad++;
    end
    n_chk++;
    if (nc != 0 || bad != 0) begin
      n_err++;
      $display("FAIL sw_glitch got=%0d/%0d exp=0/0", nc, bad);
    end
    bus.switches_raw = '0;
    idle(10);
  endtask

  task automatic test_reset_held();
    int pe = -1;
    int lg = -1;
    bus.buttons_n_raw = 2'b10;
    idle(35);
    rst = 1'b1;
    tick();
    n_chk++;
    if (dut_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_held_zero got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL rheld_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_press[0] && pe < 0) pe = k;
      if (bus.buttons_long[0] && lg < 0) lg = k;
    end
    n_chk++;
    if (pe != 6 || lg != 25) begin
      n_err++;
      $display("FAIL reset_held_timing got=%0d/%0d exp=6/25", pe, lg);
    end
    bus.buttons_n_raw = 2'b11;
    idle(10);
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] pv = '0;
    bus.buttons_n_raw = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL simul_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
      if (bus.buttons_press != '0 && pv == '0) pv = bus.buttons_press;
    end
    n_chk++;
    if (pv !== 2'b11) begin
      n_err++;
      $display("FAIL simul_press got=%b exp=11", pv);
    end
    bus.buttons_n_raw = 2'b11;
    idle(10);
  endtask

  task automatic test_random();
    logic [W-1:0] rv = '0;
    int dur [W];
    for (int b = 0; b < W; b++) dur[b] = $urandom_range(1, 10);
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < W; b++) begin
        if (dur[b] == 0) begin
          rv[b] = ~rv[b];
          dur[b] = (b < NB) ? $urandom_range(1, 45)
                            : $urandom_range(1, 12);
        end else begin
          dur[b]--;
        end
      end
      bus.buttons_n_raw = ~rv[NB-1:0];
      bus.switches_raw  = rv[W-1:NB];
      rst = ($urandom_range(0, 799) == 0);
      tick();
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_err++;
        $display("FAIL random_model k=%0d got=%h exp=%h",
                 k, dut_vec(), mdl_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_short_press();
    test_switches();
    test_reset_held();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Conditions the raw board keys and slide switches before they reach the buttons and switches PIO inputs of the Qsys system. Each raw input is synchronised and debounced. Per-button gesture events (press, long press, auto-repeat) and a switch-change event are generated in hardware, so the alarm-clock/jukebox firmware stops polling and software-debouncing. Sits between the FPGA pins and the Qsys PIO inputs; it is the input-side counterpart of the display/LED/PWM outputs.

Parameters:
N_BUTTONS, 2, number of push buttons (matches the 2-bit buttons PIO)
N_SWITCHES, 10, number of slide switches (matches the 10-bit switches PIO)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); must be >= 2
LONG_PRESS_CYCLES, 50000000, cycles a button must stay pressed before a long-press event (1 s); must be > 1
REPEAT_CYCLES, 10000000, auto-repeat period after a long press (200 ms); must be > 1

Ports:
clk_clk  in  1  system clock (50 MHz)
reset_reset  in  1  synchronous, active-high reset
buttons_n_raw  in  N_BUTTONS  raw keys, active-low, asynchronous
switches_raw  in  N_SWITCHES  raw slide switches, asynchronous
buttons_level  out  N_BUTTONS  debounced button state, 1 = pressed; drives the buttons PIO
buttons_press  out  N_BUTTONS  1-cycle pulse per bit on an accepted press
buttons_long  out  N_BUTTONS  1-cycle pulse when a press reaches LONG_PRESS_CYCLES
buttons_repeat  out  N_BUTTONS  1-cycle pulse every REPEAT_CYCLES while held after a long press
switches_level  out  N_SWITCHES  debounced switch state; drives the switches PIO
switches_changed  out  1  1-cycle pulse when any bit of switches_level changes

Behaviour:
- One clock, clk_clk. reset_reset is synchronous and active-high; all state is sampled on the rising edge.
- Reset values: all outputs 0. Synchronisers reset to the released/zero value. All counters are 0. Every button FSM is in IDLE.
- Synchroniser: 2-FF per bit. Buttons are inverted after synchronisation, so internal 1 = pressed.
- Debounce, per bit:
  - The counter increments while the synced value differs from the stable value.
  - The counter clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the stable value updates and the counter clears.
  - Latency from a clean raw edge to the level output: exactly 2 + DEBOUNCE_CYCLES edges.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored completely.
- Button FSM, one per button, all independent:
  - IDLE: on the stable 0->1 transition, go to PRESSED and pulse buttons_press in the same cycle buttons_level rises. Clear hold_cnt.
  - PRESSED: hold_cnt increments each cycle. When hold_cnt == LONG_PRESS_CYCLES-1, pulse buttons_long, go to HELD, clear rep_cnt.
  - HELD: rep_cnt increments. When rep_cnt == REPEAT_CYCLES-1, pulse buttons_repeat and clear rep_cnt; this continues indefinitely.
  - Any state: a stable 1->0 transition returns to IDLE. No pulse is emitted on release, and counters clear.
- Counter widths are sized by clog2 of their terminal values. Counters never wrap through their terminal value.
- Switches: debounced as above, no FSM. switches_changed pulses in the same cycle switches_level takes a new value. Several bits settling in the same cycle produce one pulse; different cycles produce one pulse each.
- Reset mid-operation:
  - All outputs drop to 0 on the next edge.
  - A button still held when reset deasserts is treated as a new press: press pulse at 2 + DEBOUNCE_CYCLES, and a long press is timed from that point.
  - Switches non-zero at reset release produce one switches_changed pulse after debounce.
- Simultaneous presses on several buttons produce simultaneous pulses on the corresponding bits.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: buttons_n_raw=2'b10 from 2'b11 at edge 0, held -> buttons_level=2'b01 at edge 6; buttons_press=2'b01 for exactly that cycle; other bit stays 0.
- Bounce: key0 toggles every 2 cycles for 12 cycles, then stays low -> exactly one press pulse, 6 edges after the final transition; no level change during the bounce.
- Long press + repeat: hold key0 for 60 cycles after level rise -> long at +19; repeats at +27, +35, +43, +51, +59; release -> level falls 6 edges later, no further pulses.
- Short press of 10 cycles -> one press pulse; no long, no repeat; level high for 10 cycles.
- Switches: 0x000 -> 0x2A5 -> switches_level=0x2A5 at edge 6 with one switches_changed pulse; a 3-cycle glitch on SW9 produces no change and no pulse.
- Reset during HELD with the key still held -> all outputs 0 the next cycle; after deassert, press pulse at +6 and long at +25.
